// File: rtl/alu_exec_unit_if.sv
// Handshake and data bundle between the EX-stage issue logic and the ALU execution unit.
// The unit itself connects through the slave modport.
interface alu_exec_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             valid_i;
   logic             ready_o;
   logic [3:0]       ctrl_i;
   logic [WIDTH-1:0] src1_i;
   logic [WIDTH-1:0] src2_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] result_o;
   logic             zero_o;
   logic             illegal_o;
   logic             busy_o;

   modport master (
      output valid_i, ctrl_i, src1_i, src2_i, ready_i,
      input  ready_o, valid_o, result_o, zero_o, illegal_o, busy_o
   );

   modport slave (
      input  valid_i, ctrl_i, src1_i, src2_i, ready_i,
      output ready_o, valid_o, result_o, zero_o, illegal_o, busy_o
   );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arithmetic ops plus an iterative shift-add multiply,
// with valid/ready handshakes on both the issue and result sides.
module alu_exec_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   alu_exec_unit_if.slave       exec_if
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   localparam logic [3:0] OpAnd = 4'b0000;
   localparam logic [3:0] OpOr  = 4'b0001;
   localparam logic [3:0] OpAdd = 4'b0010;
   localparam logic [3:0] OpSub = 4'b0110;
   localparam logic [3:0] OpSlt = 4'b0111;
   localparam logic [3:0] OpMul = 4'b1000;
   localparam logic [3:0] OpXor = 4'b1001;

   typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

   state_e           r_state, w_state_d;
   logic [WIDTH-1:0] r_mcand, w_mcand_d;
   logic [WIDTH-1:0] r_mplier, w_mplier_d;
   logic [WIDTH-1:0] r_acc, w_acc_d;
   logic [CntW-1:0]  r_cnt, w_cnt_d;
   logic [WIDTH-1:0] r_result, w_result_d;
   logic             r_zero, w_zero_d;
   logic             r_illegal, w_illegal_d;

   logic             w_ready;
   logic             w_accept;
   logic             w_mul_last;
   logic [WIDTH-1:0] w_acc_sum;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_ill;

   // Combinational from ready_i so a draining result and a new issue share one edge.
   assign w_ready  = (r_state == StIdle) || ((r_state == StDone) && exec_if.ready_i);
   assign w_accept = exec_if.valid_i && w_ready;

   assign w_mul_last = (r_cnt == CntW'(WIDTH - 1));
   assign w_acc_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);

   always_comb begin
      w_alu_res = '0;
      w_alu_ill = 1'b0;
      case (exec_if.ctrl_i)
         OpAdd:   w_alu_res = exec_if.src1_i + exec_if.src2_i;
         OpSub:   w_alu_res = exec_if.src1_i - exec_if.src2_i;
         OpAnd:   w_alu_res = exec_if.src1_i & exec_if.src2_i;
         OpOr:    w_alu_res = exec_if.src1_i | exec_if.src2_i;
         OpXor:   w_alu_res = exec_if.src1_i ^ exec_if.src2_i;
         OpSlt:   w_alu_res = WIDTH'($signed(exec_if.src1_i) < $signed(exec_if.src2_i));
         OpMul:   w_alu_res = '0;
         default: w_alu_ill = 1'b1;
      endcase
   end

   always_comb begin
      w_state_d   = r_state;
      w_mcand_d   = r_mcand;
      w_mplier_d  = r_mplier;
      w_acc_d     = r_acc;
      w_cnt_d     = r_cnt;
      w_result_d  = r_result;
      w_zero_d    = r_zero;
      w_illegal_d = r_illegal;

      unique case (r_state)
         StIdle, StDone: begin
            if (w_accept) begin
               if (exec_if.ctrl_i == OpMul) begin
                  w_state_d  = StMul;
                  w_mcand_d  = exec_if.src1_i;
                  w_mplier_d = exec_if.src2_i;
                  w_acc_d    = '0;
                  w_cnt_d    = '0;
               end else begin
                  w_state_d   = StDone;
                  w_result_d  = w_alu_res;
                  w_zero_d    = (w_alu_res == '0);
                  w_illegal_d = w_alu_ill;
               end
            end else if (r_state == StDone && exec_if.ready_i) begin
               w_state_d = StIdle;
            end
         end
         StMul: begin
            w_acc_d    = w_acc_sum;
            w_mcand_d  = r_mcand << 1;
            w_mplier_d = r_mplier >> 1;
            w_cnt_d    = r_cnt + CntW'(1);
            // The final iteration's sum goes straight to the result register.
            if (w_mul_last) begin
               w_state_d   = StDone;
               w_result_d  = w_acc_sum;
               w_zero_d    = (w_acc_sum == '0);
               w_illegal_d = 1'b0;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= StIdle;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_mcand   <= w_mcand_d;
         r_mplier  <= w_mplier_d;
         r_acc     <= w_acc_d;
         r_cnt     <= w_cnt_d;
         r_result  <= w_result_d;
         r_zero    <= w_zero_d;
         r_illegal <= w_illegal_d;
      end
   end

   assign exec_if.ready_o   = w_ready;
   assign exec_if.valid_o   = (r_state == StDone);
   assign exec_if.busy_o    = (r_state == StMul);
   assign exec_if.result_o  = r_result;
   assign exec_if.zero_o    = r_zero;
   assign exec_if.illegal_o = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed ops push expected results, a negedge monitor
// pops and compares each accepted output.
module tb_alu_exec_unit;

   localparam int unsigned WIDTH = 32;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             z;
      logic             ill;
   } exp_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   int   pop_cyc[$];

   alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

   alu_exec_unit #(.WIDTH(WIDTH)) u_dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .exec_if (bus)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (rst_i && bus.valid_o && bus.ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got=0x%08h expected=none", bus.result_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_result", bus.result_o, e.res);
            check("sb_zero", WIDTH'(bus.zero_o), WIDTH'(e.z));
            check("sb_illegal", WIDTH'(bus.illegal_o), WIDTH'(e.ill));
            pop_cyc.push_back(cyc);
         end
      end
   end

   // Called just after a rising edge; returns just after the accept edge.
   task automatic issue(input logic [3:0] c, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] er,
                        input logic ei, output int stalls);
      exp_t e;
      stalls = 0;
      bus.valid_i = 1'b1;
      bus.ctrl_i  = c;
      bus.src1_i  = a;
      bus.src2_i  = b;
      @(negedge clk_i);
      while (!bus.ready_o && stalls < 100) begin
         stalls++;
         @(negedge clk_i);
      end
      if (stalls >= 100) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout: got=ready_o low expected=ready_o high");
         bus.valid_i = 1'b0;
         @(posedge clk_i);
         #1;
      end else begin
         e.res = er;
         e.z   = (er == '0);
         e.ill = ei;
         exp_q.push_back(e);
         @(posedge clk_i);
         #1;
         bus.valid_i = 1'b0;
         if (c != 4'b1000) check("latency1_valid", WIDTH'(bus.valid_o), 1);
      end
   endtask

   initial begin
      int st;
      int bad;
      bus.valid_i = 1'b0;
      bus.ctrl_i  = '0;
      bus.src1_i  = '0;
      bus.src2_i  = '0;
      bus.ready_i = 1'b1;

      // Reset state
      repeat (2) @(posedge clk_i);
      #2;
      check("rst_result", bus.result_o, 0);
      check("rst_valid", WIDTH'(bus.valid_o), 0);
      check("rst_busy", WIDTH'(bus.busy_o), 0);
      check("rst_zero", WIDTH'(bus.zero_o), 0);
      check("rst_illegal", WIDTH'(bus.illegal_o), 0);
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      check("rel_ready", WIDTH'(bus.ready_o), 1);
      check("rel_valid", WIDTH'(bus.valid_o), 0);
      @(posedge clk_i);
      #1;

      // Add wrap, slt, sub
      issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, st);
      issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, st);
      issue(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, st);
      issue(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, st);
      issue(4'b0110, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, st);

      // Four back-to-back ops, including an illegal code
      issue(4'b0000, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1'b0, st);
      check("b2b_stall0", st, 0);
      issue(4'b0001, 32'h1200_0034, 32'h0056_7800, 32'h1256_7834, 1'b0, st);
      check("b2b_stall1", st, 0);
      issue(4'b1001, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, st);
      check("b2b_stall2", st, 0);
      issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, st);
      check("b2b_stall3", st, 0);
      @(negedge clk_i);
      check("b2b_consecutive", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-4], 3);
      @(posedge clk_i);
      #1;

      // Back-pressure: result held while ready_i is low
      bus.ready_i = 1'b0;
      issue(4'b0001, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 1'b0, st);
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         if (!bus.valid_o || bus.ready_o || bus.result_o !== 32'h0000_0FF0) bad++;
      end
      check("backpressure_hold", bad, 0);
      @(posedge clk_i);
      #1;
      bus.ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      check("drain_to_idle", WIDTH'(bus.valid_o), 0);

      // Multiply with a stray request inside the busy window
      issue(4'b1000, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0, st);
      bad = 0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk_i);
         if (!bus.busy_o || bus.ready_o || bus.valid_o) bad++;
         if (k == 4) begin
            bus.valid_i = 1'b1;
            bus.ctrl_i  = 4'b0010;
         end
         if (k == 7) bus.valid_i = 1'b0;
      end
      check("mul_busy_window", bad, 0);
      @(negedge clk_i);
      check("mul_valid_at_width", WIDTH'(bus.valid_o), 1);
      check("mul_busy_clear", WIDTH'(bus.busy_o), 0);
      @(posedge clk_i);
      #1;
      issue(4'b1000, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 1'b0, st);
      issue(4'b1000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, st);
      issue(4'b0010, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, st);
      check("after_mul_stall", st, 32);

      // Reset while a result is held discards it
      @(posedge clk_i);
      #1;
      bus.ready_i = 1'b0;
      issue(4'b1111, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b1, st);
      #2;
      check("held_illegal", WIDTH'(bus.illegal_o), 1);
      rst_i = 1'b0;
      #1;
      exp_q.delete();
      check("rst_held_valid", WIDTH'(bus.valid_o), 0);
      check("rst_held_illegal", WIDTH'(bus.illegal_o), 0);
      check("rst_held_zero", WIDTH'(bus.zero_o), 0);
      @(negedge clk_i);
      rst_i = 1'b1;
      bus.ready_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Abort a multiply at iteration 10
      bus.valid_i = 1'b1;
      bus.ctrl_i  = 4'b1000;
      bus.src1_i  = 32'h0000_0003;
      bus.src2_i  = 32'h0000_0005;
      @(posedge clk_i);
      #1;
      bus.valid_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #3;
      check("abort_was_busy", WIDTH'(bus.busy_o), 1);
      rst_i = 1'b0;
      #1;
      check("abort_busy", WIDTH'(bus.busy_o), 0);
      check("abort_valid", WIDTH'(bus.valid_o), 0);
      check("abort_result", bus.result_o, 0);
      @(negedge clk_i);
      rst_i = 1'b1;
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk_i);
         if (bus.valid_o || bus.busy_o) bad++;
      end
      check("abort_no_valid", bad, 0);
      check("sb_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 4-bit ALU control code produced by the ALU controller in the EX stage.
- Performs the operation selected by ctrl_i on two operands and delivers a registered result.
- All ops except multiply complete in one cycle.
- Multiply (code 1000) runs as an iterative shift-add over WIDTH cycles; it stalls the upstream stage through a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand/result width in bits; also the multiply iteration count.

Ports:
- clk_i, input, 1, clock; all state updates on the rising edge.
- rst_i, input, 1, asynchronous active-low reset.
- valid_i, input, 1, upstream presents an operation.
- ready_o, output, 1, unit can accept an operation this cycle.
- ctrl_i, input, 4, ALU control code.
- src1_i, input, WIDTH, operand A.
- src2_i, input, WIDTH, operand B.
- valid_o, output, 1, result_o/zero_o/illegal_o are valid.
- ready_i, input, 1, downstream accepts the result this cycle.
- result_o, output, WIDTH, registered result.
- zero_o, output, 1, result_o == 0.
- illegal_o, output, 1, the completed op had an unsupported code.
- busy_o, output, 1, multiply in progress.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, iteration counter=0.
  - result_o=0, zero_o=0, illegal_o=0, valid_o=0, busy_o=0.
  - ready_o=1 once reset deasserts.
- Reset mid-operation aborts any multiply and discards any held result; nothing is emitted afterwards.
- States: IDLE, MUL, DONE.
- Accept occurs on an edge where valid_i && ready_o. ctrl_i, src1_i and src2_i are captured on that edge; later changes to these inputs have no effect.
- ready_o = (state==IDLE) || (state==DONE && ready_i). This is a combinational path from ready_i, which permits back-to-back issue.
- Code map (all arithmetic modulo 2^WIDTH, no overflow flag):
  - 0010 add
  - 0110 sub (A-B)
  - 0000 and
  - 0001 or
  - 1001 xor
  - 0111 slt: signed compare, result 1 if A<B else 0
  - 1000 mul: low WIDTH bits of A*B
  - any other code: result 0, illegal_o=1
- Single-cycle op accepted: result is registered on the accept edge, state→DONE, valid_o=1 on the next cycle (latency 1).
- mul accepted:
  - state→MUL, busy_o=1; multiplicand=A, multiplier=B, accumulator=0, counter=0.
  - Each MUL cycle: if multiplier[0], accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++.
  - After WIDTH iterations: result_o=accumulator, state→DONE, busy_o=0.
  - valid_o rises exactly WIDTH cycles after the accept edge.
- DONE:
  - Outputs are held stable while ready_i=0.
  - On ready_i=1 without a new accept: state→IDLE, valid_o=0.
  - On ready_i=1 with a simultaneous accept: the new op loads in the same edge (DONE→DONE for a single-cycle op, DONE→MUL for mul) with no bubble.
- zero_o and illegal_o are registered together with result_o.
- valid_i during MUL is ignored (ready_o=0); upstream holds its request.
- valid_o never asserts in IDLE or MUL.

Test Plan:
- Reset:
  - Assert rst_i=0 mid-cycle with no clock edge → all outputs 0 immediately.
  - Release → ready_o=1, valid_o=0.
- Add wrap:
  - ctrl=0010, A=0x7FFFFFFF, B=0x00000001 → next cycle valid_o=1, result_o=0x80000000, zero_o=0.
  - ctrl=0010, A=0xFFFFFFFF, B=1 → result 0, zero_o=1.
- slt/sub:
  - ctrl=0111, A=0xFFFFFFFF, B=0x00000001 → result 1.
  - ctrl=0110, A=5, B=7 → result 0xFFFFFFFE.
- Multiply (ctrl=1000, A=0x0000FFFF, B=0x00010001):
  - busy_o=1 and ready_o=0 for 32 cycles.
  - A valid_i pulse during that window is not accepted.
  - valid_o=1 at cycle 32 with result 0xFFFFFFFF.
- Back-pressure/throughput:
  - Four back-to-back single-cycle ops with ready_i=1 → four results on four consecutive cycles.
  - Hold ready_i=0 for 3 cycles → result_o and valid_o stable, ready_o=0.
- Illegal/abort:
  - ctrl=1111 → result 0, illegal_o=1.
  - Start a mul, pull rst_i low at iteration 10 → outputs clear immediately and no valid_o follows after release.
